// File: rtl/tlc_pkg.sv
// ============================================================================
// Module   : tlc_pkg
// Brief    : Shared lamp encodings, phase enum and direction constants for the
//            two-direction intersection controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tlc_pkg;

  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b100;

  typedef enum logic [1:0] {
    TLC_GREEN   = 2'd0,
    TLC_YELLOW  = 2'd1,
    TLC_ALL_RED = 2'd2,
    TLC_WALK    = 2'd3
  } tlc_st_t;

  localparam logic [1:0] ST_GREEN   = TLC_GREEN;
  localparam logic [1:0] ST_YELLOW  = TLC_YELLOW;
  localparam logic [1:0] ST_ALL_RED = TLC_ALL_RED;
  localparam logic [1:0] ST_WALK    = TLC_WALK;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Lamp shown by one head: only the head being served ever leaves red.
  function automatic logic [2:0] head_lamp(input logic served, input logic [1:0] st);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    if (served && st == ST_GREEN)  lamp = LAMP_GRN;
    if (served && st == ST_YELLOW) lamp = LAMP_YEL;
    return lamp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlc_phase_timer.sv
// ============================================================================
// Module   : tlc_phase_timer
// Brief    : Phase down-counter; reloads with load_val on the enabled edge
//            where it sits at zero, and flags done while at zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tlc_phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_q == '0) cnt_d = load_val;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_intersection_ctrl.sv
// ============================================================================
// Module   : traffic_intersection_ctrl
// Brief    : NS/EW intersection sequencer (green, yellow, all-red, optional
//            pedestrian walk). Walk logic is built only when TLC_PED_EN is
//            defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_intersection_ctrl
  import tlc_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 30,
  parameter int YELLOW_CYC = 10,
  parameter int ALLRED_CYC = 4,
  parameter int WALK_CYC   = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  if (GREEN_CYC  < 1 || GREEN_CYC  > (1 << CNT_W) ||
      YELLOW_CYC < 1 || YELLOW_CYC > (1 << CNT_W) ||
      ALLRED_CYC < 1 || ALLRED_CYC > (1 << CNT_W) ||
      WALK_CYC   < 1 || WALK_CYC   > (1 << CNT_W)) begin : g_bad_duration
    $error("traffic_intersection_ctrl: every phase duration must lie in [1, 2**CNT_W]");
  end

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
`ifdef TLC_PED_EN
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);
`endif

  logic [1:0]       st_d, st_q;
  logic             dir_d, dir_q;
  logic [1:0]       nxt_st;
  logic             nxt_dir;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] timer_cnt_unused;
  logic             done;
  logic             advance;

`ifdef TLC_PED_EN
  logic ped_pend_d, ped_pend_q;
`endif

  tlc_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load_val (load_val),
    .cnt      (timer_cnt_unused),
    .done     (done)
  );

  assign advance = en & done;

  // Successor phase and its reload value, applied only when the timer expires.
  always_comb begin
    nxt_st   = ST_GREEN;
    nxt_dir  = dir_q;
    load_val = GREEN_LD;
    case (st_q)
      ST_GREEN: begin
        nxt_st   = ST_YELLOW;
        load_val = YELLOW_LD;
      end
      ST_YELLOW: begin
        nxt_st   = ST_ALL_RED;
        nxt_dir  = ~dir_q;
        load_val = ALLRED_LD;
      end
      ST_ALL_RED: begin
`ifdef TLC_PED_EN
        if (ped_pend_q) begin
          nxt_st   = ST_WALK;
          load_val = WALK_LD;
        end
`endif
      end
      default: begin
        nxt_st   = ST_GREEN;
        load_val = GREEN_LD;
      end
    endcase
  end

  always_comb begin
    st_d  = st_q;
    dir_d = dir_q;
    if (advance) begin
      st_d  = nxt_st;
      dir_d = nxt_dir;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= ST_ALL_RED;
      dir_q <= DIR_NS;
    end else begin
      st_q  <= st_d;
      dir_q <= dir_d;
    end
  end

`ifdef TLC_PED_EN
  // A request on the entry edge re-arms the pending flag for the next all-red.
  assign ped_pend_d = ped_req | (ped_pend_q & ~(advance & (nxt_st == ST_WALK)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ped_pend_q <= 1'b0;
    else       ped_pend_q <= ped_pend_d;
  end

  assign ped_walk = (st_q == ST_WALK);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_walk       = 1'b0;
`endif

  assign ns_light = head_lamp(dir_q == DIR_NS, st_q);
  assign ew_light = head_lamp(dir_q == DIR_EW, st_q);
  assign phase    = {dir_q, st_q};

endmodule

`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
// ============================================================================
// Module   : tb_traffic_intersection_ctrl
// Brief    : Directed + random bench for traffic_intersection_ctrl against a
//            remaining-cycles reference model (follows TLC_PED_EN if defined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_traffic_intersection_ctrl;

  localparam int GRN = 5;
  localparam int YEL = 2;
  localparam int AR  = 1;
  localparam int WLK = 3;
`ifdef TLC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  // Reference model: phase id (0 green, 1 yellow, 2 all-red, 3 walk),
  // head being served, visible cycles left in this phase, pending request.
  int m_ph;
  bit m_dir;
  int m_left;
  bit m_pend;

  traffic_intersection_ctrl #(
    .CNT_W      (4),
    .GREEN_CYC  (GRN),
    .YELLOW_CYC (YEL),
    .ALLRED_CYC (AR),
    .WALK_CYC   (WLK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph   = 2;
    m_dir  = 1'b0;
    m_left = AR;
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit pr);
    bit enter_walk;
    enter_walk = 1'b0;
    if (e) begin
      if (m_left > 1) begin
        m_left--;
      end else begin
        case (m_ph)
          0: begin m_ph = 1; m_left = YEL; end
          1: begin m_ph = 2; m_left = AR; m_dir = !m_dir; end
          2: begin
            if (PED && m_pend) begin m_ph = 3; m_left = WLK; enter_walk = 1'b1; end
            else               begin m_ph = 0; m_left = GRN; end
          end
          default: begin m_ph = 0; m_left = GRN; end
        endcase
      end
    end
    if (PED) m_pend = pr | (m_pend & !enter_walk);
  endtask

  function automatic logic [2:0] exp_lamp(input bit served);
    if (served && m_ph == 0) return 3'b100;
    if (served && m_ph == 1) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".ns"},    {1'b0, ns_light}, {1'b0, exp_lamp(!m_dir)});
    chk({tag, ".ew"},    {1'b0, ew_light}, {1'b0, exp_lamp(m_dir)});
    chk({tag, ".walk"},  {3'b0, ped_walk}, {3'b0, (m_ph == 3)});
    chk({tag, ".phase"}, {1'b0, phase},    {1'b0, m_dir, 2'(m_ph)});
    chk({tag, ".safe"},  {3'b0, (ns_light != 3'b001 && ew_light != 3'b001)}, 4'h0);
  endtask

  task automatic step(input bit e, input bit pr, input string tag);
    en      = e;
    ped_req = pr;
    @(posedge clk);
    model_edge(e, pr);
    #1;
    chk_all(tag);
  endtask

  initial begin
    int green_cnt;
    int walk_cnt;
    int guard;
    bit e;
    bit pr;

    reset   = 1'b1;
    en      = 1'b0;
    ped_req = 1'b0;
    model_reset();
    #12;
    chk("rst.ns", {1'b0, ns_light}, 4'h1);
    chk("rst.ew", {1'b0, ew_light}, 4'h1);
    chk("rst.walk", {3'b0, ped_walk}, 4'h0);
    chk("rst.phase", {1'b0, phase}, 4'h2);
    #2 reset = 1'b0;

    // Free run: two full 16-cycle periods plus change.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, "free");

    // Freeze during the third NS green cycle.
    reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    green_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, "hold.pre");
      if (ns_light == 3'b100) green_cnt++;
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, "hold.off");
      if (ns_light == 3'b100) green_cnt++;
    end
    guard = 0;
    while (ns_light == 3'b100 && guard < 20) begin
      step(1'b1, 1'b0, "hold.post");
      if (ns_light == 3'b100) green_cnt++;
      guard++;
    end
    chk("hold.green_total", 4'(green_cnt), 4'd12);
    chk("hold.then_yellow", {1'b0, ns_light}, 4'h2);

    // Pedestrian pulse during NS green.
    reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    step(1'b1, 1'b0, "ped.a");
    step(1'b1, 1'b1, "ped.req");
    walk_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, "ped.run");
      if (ped_walk) walk_cnt++;
    end
    chk("ped.walk_cycles", 4'(walk_cnt), PED ? 4'd3 : 4'd0);

`ifdef TLC_PED_EN
    // Hold the request through a walk phase; the next all-red must walk again.
    guard = 0;
    while (m_ph != 3 && guard < 40) begin
      step(1'b1, (m_ph == 2) ? 1'b1 : 1'b0, "pedhold.seek");
      guard++;
    end
    chk("pedhold.reached_walk", {3'b0, ped_walk}, 4'h1);
    while (m_ph == 3 && guard < 60) begin
      step(1'b1, 1'b1, "pedhold.walk");
      guard++;
    end
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, "pedhold.after");
`endif

    // Random enable / request traffic.
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 9) == 0);
      step(e, pr, "rand");
    end

    // Asynchronous reset in the middle of NS yellow.
    guard = 0;
    while (!(m_ph == 1 && m_dir == 1'b0) && guard < 80) begin
      step(1'b1, 1'b0, "ayel.seek");
      guard++;
    end
    chk("ayel.found", {1'b0, ns_light}, 4'h2);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("ayel.ns", {1'b0, ns_light}, 4'h1);
    chk("ayel.ew", {1'b0, ew_light}, 4'h1);
    chk("ayel.walk", {3'b0, ped_walk}, 4'h0);
    chk("ayel.phase", {1'b0, phase}, 4'h2);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "ayel.restart");

    // Constant request: identical to free run when walks are not built.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, "preqhi");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Parametrised two-direction intersection controller that sequences a north-south (NS) and an east-west (EW) signal head through green, yellow and all-red clearance phases with per-phase programmable durations. It adds a phase-hold enable and an optional pedestrian walk phase. It sits at the top of the signal datapath and drives the lamp-driver outputs directly. It supersedes the single-head red/yellow/green controller.

## Interface
- `CNT_W`, 8, width of the phase down-counter.
- `GREEN_CYC`, 30, green duration in enabled cycles.
- `YELLOW_CYC`, 10, yellow duration in enabled cycles.
- `ALLRED_CYC`, 4, all-red clearance duration in enabled cycles.
- `WALK_CYC`, 20, pedestrian walk duration in enabled cycles.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance enable; 0 freezes phase and counter.
- `ped_req`  in  1  pedestrian request, level or pulse.
- `ns_light`  out  3  NS head, one-hot {G,Y,R}: 001 red, 010 yellow, 100 green.
- `ew_light`  out  3  EW head, same encoding.
- `ped_walk`  out  1  walk indication.
- `phase`  out  3  {dir, st[1:0]} for debug/status.

## Operation
- State: `st` in {GREEN=0, YELLOW=1, ALL_RED=2, WALK=3}, `dir` (0=NS served next/now, 1=EW), `cnt[CNT_W-1:0]`, `ped_pend`.
- Reset (async): `st`=ALL_RED, `dir`=0, `cnt`=ALLRED_CYC-1, `ped_pend`=0. Outputs: `ns_light`=001, `ew_light`=001, `ped_walk`=0, `phase`=3'b010.
- Each rising edge with `en`=1:
  - If `cnt`≠0, decrement `cnt`.
  - Otherwise, advance and load `cnt` with the new phase's duration minus 1.
- Transitions on `cnt`==0:
  - GREEN→YELLOW.
  - YELLOW→ALL_RED, toggling `dir`.
  - ALL_RED→WALK if `ped_pend`, else GREEN.
  - WALK→GREEN.
- Outputs decode from registered state only; no input reaches an output combinationally.
  - The head selected by `dir` shows 100 in GREEN and 010 in YELLOW; every other head/phase combination shows 001.
  - `ped_walk`=1 only in WALK.
- `ped_pend` handling:
  - Set on any edge with `ped_req`=1.
  - Cleared on the edge entering WALK, unless `ped_req`=1 on that same edge, in which case it stays set (new request wins).
  - A request arriving during WALK is served at the next ALL_RED.
- `en`=0: `st`, `dir` and `cnt` hold; `ped_pend` still captures requests.
- Safety invariant: `ns_light` and `ew_light` are never both non-001.
- Durations must be ≥1 and ≤2^CNT_W. An elaboration-time check fails otherwise.

## Timing
- Each phase is visible for exactly its DUR enabled cycles. Disabled cycles stretch the phase without consuming count.
- Phase change takes effect 1 cycle after the edge on which `cnt`==0 is sampled, with no bubble.
- Free-running cycle period without walks: 2·(GREEN_CYC+YELLOW_CYC+ALLRED_CYC).
- Each served walk adds WALK_CYC cycles.
- After reset deassertion, the first edge starts the ALLRED_CYC countdown, followed by NS green.
- Reset mid-phase forces outputs to all-red immediately, without waiting for a clock edge.

## Configuration
- `TLC_PED_EN` defined: pedestrian logic as described above.
- `TLC_PED_EN` undefined: `ped_req` is ignored, `ped_pend` and the WALK state are not built, `ped_walk` is tied 0, and ALL_RED always goes to GREEN.
- Ports are identical in both builds.

## Structure
- Shared package `tlc_pkg`:
  - Lamp encodings `LAMP_RED`/`LAMP_YEL`/`LAMP_GRN`.
  - Phase enum `tlc_st_t`.
  - Direction constants.
- Sub-module `tlc_phase_timer`: loadable down-counter with enable and a `done` (cnt==0) flag, instantiated once.

## Test plan
All scenarios use GREEN_CYC=5, YELLOW_CYC=2, ALLRED_CYC=1, WALK_CYC=3, CNT_W=4, with the invariant checked every cycle.
- Reset, then `en`=1 free-run: the sequence is both 001 ×1, NS 100 ×5, NS 010 ×2, both 001 ×1, EW 100 ×5, EW 010 ×2, repeating with period 16.
- `en`=0 for 7 cycles during the third NS green cycle: lights hold at 100 and `cnt` holds; NS green totals 12 cycles, then 010.
- `ped_req` pulse during NS green (`TLC_PED_EN`): after NS yellow, both 001 ×1, then `ped_walk`=1 with both 001 ×3, then EW 100. That period measures 19.
- `ped_req` held during WALK: `ped_pend` remains 1; the next ALL_RED (after EW yellow) enters WALK again, then pending clears.
- `reset` asserted mid NS yellow, between clock edges: outputs become 001/001, `ped_walk`=0 and `phase`=010 immediately; the sequence restarts per scenario 1.
- Build without `TLC_PED_EN` and drive `ped_req`=1 constantly: timing is identical to scenario 1 and `ped_walk` stays 0.
